// File: rtl/sipo_word_deser.sv
// Serial-in/parallel-out word deserialiser with a bit counter, a holding
// register, a valid/ready handshake and a sticky overrun flag.
module sipo_word_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             DatIn,
  input  logic             sync,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] ShiftOut,
  output logic [WIDTH-1:0] DatOut,
  output logic             out_valid,
  output logic             overrun,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             done;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    dat_d = dat_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    done  = 1'b0;

    if (sync) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (ena) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], DatIn};
      end else begin
        sr_d = {DatIn, sr_q[WIDTH-1:1]};
      end
      done  = (cnt_q == LAST);
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end

    // A completion reloads the holding register even if unconsumed.
    if (done) begin
      dat_d = sr_d;
      vld_d = 1'b1;
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end

    // Set beats clear when both happen on the same edge.
    if (done && vld_q && !out_ready) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      dat_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

  assign ShiftOut  = sr_q;
  assign DatOut    = dat_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_word_deser.sv
// Bench for sipo_word_deser: MSB-first and LSB-first instances share stimulus;
// a bit-level model queues expected words that are popped at each completion.
module tb_sipo_word_deser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic DatIn = 1'b0;
  logic sync = 1'b0;
  logic out_ready = 1'b0;
  logic ovr_clr = 1'b0;

  logic [7:0] sh_m, dat_m, sh_l, dat_l;
  logic       vld_m, ovr_m, vld_l, ovr_l;
  logic [2:0] cnt_m, cnt_l;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_msb = 8'h00;
  logic [7:0] m_lsb = 8'h00;
  int         m_cnt = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  sipo_word_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ena(ena), .DatIn(DatIn), .sync(sync),
    .out_ready(out_ready), .ovr_clr(ovr_clr),
    .ShiftOut(sh_m), .DatOut(dat_m), .out_valid(vld_m),
    .overrun(ovr_m), .bit_cnt(cnt_m)
  );

  sipo_word_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .ena(ena), .DatIn(DatIn), .sync(sync),
    .out_ready(out_ready), .ovr_clr(ovr_clr),
    .ShiftOut(sh_l), .DatOut(dat_l), .out_valid(vld_l),
    .overrun(ovr_l), .bit_cnt(cnt_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_msb = 8'h00;
    m_lsb = 8'h00;
    m_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    ena   = 1'b1;
    DatIn = b;
    m_msb = {m_msb[6:0], b};
    m_lsb = {b, m_lsb[7:1]};
    m_cnt++;
    if (m_cnt == 8) begin
      q_m.push_back(m_msb);
      q_l.push_back(m_lsb);
      m_cnt = 0;
    end
    tick();
  endtask

  task automatic send_byte(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_bit(w[i]);
  endtask

  function automatic logic [7:0] pop_m();
    if (q_m.size() == 0) return 'x;
    return q_m.pop_front();
  endfunction

  function automatic logic [7:0] pop_l();
    if (q_l.size() == 0) return 'x;
    return q_l.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    model_clear();
    for (int c = 0; c < 2; c++) begin
      DatIn = c[0];
      tick();
      n_cmp++;
      if ({sh_m, dat_m, vld_m, ovr_m, cnt_m} !== 21'd0) begin
        n_err++;
        $display("FAIL reset_m: got %h/%h/%b/%b/%0d want all 0",
                 sh_m, dat_m, vld_m, ovr_m, cnt_m);
      end
      n_cmp++;
      if ({sh_l, dat_l, vld_l, ovr_l, cnt_l} !== 21'd0) begin
        n_err++;
        $display("FAIL reset_l: got %h/%h/%b/%b/%0d want all 0",
                 sh_l, dat_l, vld_l, ovr_l, cnt_l);
      end
    end
    rst = 1'b0;
    ena = 1'b0;
    tick();
  endtask

  task automatic test_basic_msb();
    logic [7:0] e;
    out_ready = 1'b1;
    send_byte(8'b0101_1001, 8);
    ena = 1'b0;
    e = pop_m();
    n_cmp++;
    if (dat_m !== e || e !== 8'h59) begin
      n_err++;
      $display("FAIL basic_dat: got %h want %h (59)", dat_m, e);
    end
    n_cmp++;
    if (vld_m !== 1'b1 || cnt_m !== 3'd0 || ovr_m !== 1'b0) begin
      n_err++;
      $display("FAIL basic_flags: got v%b c%0d o%b want v1 c0 o0",
               vld_m, cnt_m, ovr_m);
    end
    e = pop_l();
    n_cmp++;
    if (dat_l !== e) begin
      n_err++;
      $display("FAIL basic_lsb_dat: got %h want %h", dat_l, e);
    end
    tick();
    n_cmp++;
    if (vld_m !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pulse: got valid %b want 0", vld_m);
    end
  endtask

  task automatic test_lsb_gaps();
    logic [7:0] e;
    out_ready = 1'b1;
    send_byte(8'b0101_1001, 4);
    ena = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_cmp++;
      if (sh_l !== m_lsb || cnt_l !== 3'd4) begin
        n_err++;
        $display("FAIL gap_hold: got %h c%0d want %h c4", sh_l, cnt_l, m_lsb);
      end
    end
    send_byte(8'b1001_0000, 4);
    ena = 1'b0;
    e = pop_l();
    n_cmp++;
    if (dat_l !== e || e !== 8'h9A || vld_l !== 1'b1) begin
      n_err++;
      $display("FAIL gap_dat: got %h v%b want %h (9A) v1", dat_l, vld_l, e);
    end
    e = pop_m();
    n_cmp++;
    if (dat_m !== e) begin
      n_err++;
      $display("FAIL gap_msb_dat: got %h want %h", dat_m, e);
    end
    tick();
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    out_ready = 1'b0;
    send_byte(8'hA5, 8);
    e = pop_m();
    void'(pop_l());
    n_cmp++;
    if (dat_m !== e || vld_m !== 1'b1 || ovr_m !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_w1: got %h v%b o%b want %h v1 o0",
               dat_m, vld_m, ovr_m, e);
    end
    send_byte(8'h3C, 8);
    ena = 1'b0;
    e = pop_m();
    n_cmp++;
    if (dat_m !== e || vld_m !== 1'b1 || ovr_m !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_w2: got %h v%b o%b want %h v1 o1",
               dat_m, vld_m, ovr_m, e);
    end
    e = pop_l();
    n_cmp++;
    if (dat_l !== e || ovr_l !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_lsb: got %h o%b want %h o1", dat_l, ovr_l, e);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (vld_m !== 1'b0 || ovr_m !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_ack: got v%b o%b want v0 o1", vld_m, ovr_m);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_cmp++;
    if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clr: got %b/%b want 0/0", ovr_m, ovr_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    out_ready = 1'b0;
    send_byte(8'hC3, 8);
    e = pop_m();
    void'(pop_l());
    n_cmp++;
    if (dat_m !== e || vld_m !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_w1: got %h v%b want %h v1", dat_m, vld_m, e);
    end
    send_byte(8'h5E, 7);
    out_ready = 1'b1;
    send_bit(1'b0);
    ena = 1'b0;
    e = pop_m();
    n_cmp++;
    if (dat_m !== e || vld_m !== 1'b1 || ovr_m !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_same_edge: got %h v%b o%b want %h v1 o0",
               dat_m, vld_m, ovr_m, e);
    end
    e = pop_l();
    n_cmp++;
    if (dat_l !== e || ovr_l !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_lsb: got %h o%b want %h o0", dat_l, ovr_l, e);
    end
    tick();
    n_cmp++;
    if (vld_m !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got v%b want 0", vld_m);
    end
  endtask

  task automatic test_sync_reset();
    logic [7:0] e;
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      send_byte(8'hE0, 3);
      ena   = 1'b1;
      DatIn = 1'b1;
      if (r == 0) sync = 1'b1;
      else rst = 1'b1;
      tick();
      sync = 1'b0;
      rst  = 1'b0;
      model_clear();
      n_cmp++;
      if (cnt_m !== 3'd0 || sh_m !== 8'h00 || sh_l !== 8'h00) begin
        n_err++;
        $display("FAIL restart%0d: got c%0d %h/%h want c0 00/00",
                 r, cnt_m, sh_m, sh_l);
      end
      if (r == 1) begin
        n_cmp++;
        if (dat_m !== 8'h00 || vld_m !== 1'b0) begin
          n_err++;
          $display("FAIL rst_clear: got %h v%b want 00 v0", dat_m, vld_m);
        end
      end
      send_byte(8'h0F, 8);
      ena = 1'b0;
      e = pop_m();
      n_cmp++;
      if (dat_m !== e || e !== 8'h0F || cnt_m !== 3'd0 || vld_m !== 1'b1) begin
        n_err++;
        $display("FAIL restart%0d_word: got %h c%0d v%b want %h c0 v1",
                 r, dat_m, cnt_m, vld_m, e);
      end
      e = pop_l();
      n_cmp++;
      if (dat_l !== e) begin
        n_err++;
        $display("FAIL restart%0d_lsb: got %h want %h", r, dat_l, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_msb();
    test_lsb_gaps();
    test_overrun();
    test_back_to_back();
    test_sync_reset();
    n_cmp++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d/%0d left want 0/0",
               q_m.size(), q_l.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_word_deser.md
# sipo_word_deser

Parametrised serial-in/parallel-out deserialiser, successor to the fixed 8-bit left-shift SIPO register in the SPI receive path. It shifts one bit per enabled cycle, MSB-first or LSB-first, and counts bits to detect word boundaries. Each completed word is captured into a holding register and presented to the SPI controller through a valid/ready handshake with sticky overrun detection. A frame-sync input realigns the bit counter when chip-select (re)asserts.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2..32
- MSB_FIRST, 1, 1 = shift left (first bit lands in MSB), 0 = shift right (first bit lands in LSB)

Ports (CW = $clog2(WIDTH)):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  sample strobe; DatIn is shifted in on each rising edge where ena=1
- DatIn  in  1  serial data bit
- sync  in  1  frame restart; discards the partial word and clears the bit counter
- out_ready  in  1  consumer accepts DatOut on the rising edge where out_valid=1 and out_ready=1
- ovr_clr  in  1  clears the sticky overrun flag
- ShiftOut  out  WIDTH  live shift-register contents
- DatOut  out  WIDTH  holding register containing the last completed word
- out_valid  out  1  DatOut holds an unconsumed word
- overrun  out  1  sticky flag; a word completed while the previous word was still unconsumed
- bit_cnt  out  CW  number of bits received in the current word (0..WIDTH-1)

## Operation
- Priority on each edge: rst > sync > ena.
- rst=1: ShiftOut=0, DatOut=0, out_valid=0, overrun=0, bit_cnt=0.
- sync=1 (rst=0): ShiftOut<=0 and bit_cnt<=0. DatIn is ignored even if ena=1. DatOut, out_valid and overrun are unaffected, and the out_ready handshake still completes.
- Shift (ena=1, sync=0):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], DatIn}.
  - MSB_FIRST=0: sr <= {DatIn, sr[WIDTH-1:1]}.
- Counter: if bit_cnt==WIDTH-1, the edge is a word completion and bit_cnt wraps to 0; otherwise bit_cnt<=bit_cnt+1. bit_cnt never reaches WIDTH.
- ena=0: sr and bit_cnt hold.
- Word completion: DatOut <= next sr value (the new word including the current DatIn) and out_valid<=1.
- Handshake: out_valid=1 and out_ready=1 with no completion on that edge → out_valid<=0.
- Completion and handshake on the same edge: the old word is consumed, the new word loads, out_valid stays 1, and overrun is not set.
- Completion while out_valid=1 and out_ready=0: overrun<=1, DatOut is overwritten with the new word (newest wins), and out_valid stays 1.
- ovr_clr=1: overrun<=0, unless an overrun condition occurs on the same edge, in which case set wins.
- out_ready while out_valid=0 has no effect.

## Timing
- ShiftOut and bit_cnt reflect a sample on the cycle after the ena edge.
- DatOut and out_valid update one cycle after the WIDTH-th enabled sample, i.e. they are visible in the cycle following the completing edge.
- Back-to-back words are supported with ena=1 every cycle. A word completes every WIDTH cycles with no dead cycle between words.
- out_valid has a minimum high time of one cycle. out_ready may be tied high, which gives a one-cycle valid pulse per word.
- Reset mid-word takes effect immediately: the partial word is lost and the next enabled bit is bit 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=8 unless stated otherwise.
- Reset: hold rst=1 for 2 cycles with ena=1 and DatIn toggling → every output is 0, and bit_cnt stays 0.
- MSB_FIRST=1 basic word: ena=1, out_ready=1, DatIn stream 0,1,0,1,1,0,0,1 → one cycle after the 8th bit, DatOut=8'h59 with out_valid=1 for exactly one cycle, bit_cnt=0, overrun=0.
- MSB_FIRST=0 with ena gaps: same bit stream, with ena=0 for 3 cycles between bits 4 and 5 → DatOut=8'h9A. ShiftOut and bit_cnt hold during the gaps.
- Overrun: out_ready=0, stream 8'hA5 then 8'h3C continuously → after word 1, out_valid=1 and DatOut=A5. After word 2, DatOut=3C and overrun=1. Then pulse out_ready → out_valid=0 while overrun stays 1. Then pulse ovr_clr → overrun=0.
- Simultaneous events: out_valid=1 and out_ready=1 on the edge that completes word 2 → out_valid stays 1, DatOut=word 2, overrun=0.
- Sync/reset mid-word: feed 3 bits (1,1,1), pulse sync with ena=1 and DatIn=1, then feed 8'h0F MSB-first → DatOut=8'h0F and bit_cnt returns to 0. Repeat the sequence with rst in place of sync → identical word, with DatOut and out_valid cleared at the reset.
